// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 multi-cycle control slice.
// Contents: opcode values (IR[15:13]), ALU operation codes, PC source select
// codes, and the sequencer state encoding.
package mips16_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_ILL  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SADD = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;

    localparam logic [1:0] PC_INC = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

endpackage

// File: rtl/mips16_mem_watchdog.sv
// Memory request watchdog.
// Counts cycles in which a request is outstanding without acknowledge and
// flags a timeout in the cycle the count would reach MEM_TIMEOUT.
// Ports: clk, rst (async, active high), clear (restart count on entry to a
//        memory state), req, ack, timeout (combinational).
module mips16_mem_watchdog #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic req,
    input  logic ack,
    output logic timeout
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (req && !ack)
            count <= count + 1'b1;
    end

    // Fires on the waiting cycle that would bring the count to the limit;
    // an ack in that same cycle suppresses it.
    assign timeout = req && !ack && (count == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips16_multicycle_ctrl.sv
// Multi-cycle control sequencer for the MIPS16 datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and decodes the
// datapath strobes combinationally from state (plus mem_ack/alu_zero).
// Ports: clk, rst (async, active high), start, opcode, alu_zero, mem_ack in;
//        mem_req, mem_we, mem_sel, ir_we, pc_we, pc_src, alu_op, alu_src_imm,
//        reg_we, wb_sel, busy, halted, err, retired out.
module mips16_multicycle_ctrl
    import mips16_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             wb_sel,
    output logic             busy,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    state_t state, next;
    logic   retire;
    logic   timeout;
    logic   wd_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired <= '0;
        else if (retire)
            retired <= retired + 1'b1;
    end

    // Restart the watchdog whenever a memory state is freshly entered
    // (SW goes MEM -> FETCH directly, so this must be edge based).
    assign wd_clear = (next == S_FETCH || next == S_MEM) && (next != state);

    mips16_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clear  (wd_clear),
        .req    (mem_req),
        .ack    (mem_ack),
        .timeout(timeout)
    );

    always_comb begin
        next        = state;
        retire      = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_sel     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PC_INC;
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel      = 1'b0;
        busy        = 1'b0;
        halted      = 1'b0;
        err         = 1'b0;

        // ALU controls are held from EXEC through MEM/WB so the address and
        // result stay valid while the datapath consumes them.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            case (opcode)
                OP_ADD:       alu_op = ALU_SADD;
                OP_ADDI:      begin alu_op = ALU_SADD; alu_src_imm = 1'b1; end
                OP_LW, OP_SW: begin alu_op = ALU_ADD;  alu_src_imm = 1'b1; end
                OP_BEQ:       alu_op = ALU_SUB;
                default:      alu_op = ALU_ADD;
            endcase
        end

        case (state)
            S_IDLE: begin
                if (start) next = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    next  = S_DECODE;
                end else if (timeout) begin
                    next = S_ERR;
                end
            end
            S_DECODE: begin
                busy = 1'b1;
                case (opcode)
                    OP_J: begin
                        pc_we  = 1'b1;
                        pc_src = PC_JMP;
                        retire = 1'b1;
                        next   = S_FETCH;
                    end
                    OP_HALT: begin
                        retire = 1'b1;
                        next   = S_HALT;
                    end
                    OP_ILL:  next = S_ERR;
                    default: next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                busy = 1'b1;
                case (opcode)
                    OP_BEQ: begin
                        retire = 1'b1;
                        next   = S_FETCH;
                        if (alu_zero) begin
                            pc_we  = 1'b1;
                            pc_src = PC_BR;
                        end
                    end
                    OP_LW, OP_SW:  next = S_MEM;
                    OP_ADD, OP_ADDI: next = S_WB;
                    default:       next = S_ERR;
                endcase
            end
            S_MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (mem_ack) begin
                    if (opcode == OP_SW) begin
                        retire = 1'b1;
                        next   = S_FETCH;
                    end else begin
                        next = S_WB;
                    end
                end else if (timeout) begin
                    next = S_ERR;
                end
            end
            S_WB: begin
                busy   = 1'b1;
                reg_we = 1'b1;
                wb_sel = (opcode == OP_LW);
                retire = 1'b1;
                next   = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_ERR:   err    = 1'b1;
            default: next   = S_ERR;
        endcase
    end

endmodule
